axi_write_packer: RTL

- Successor to the single-beat merger write controller. Drains the merger-tree output FIFO and packs RATIO = C_AXIS_TDATA_WIDTH/C_SORTER_BIT_WIDTH sorter items into each AXI4-Stream beat.
- Frames the stream into packets of C_BURST_BEATS beats with tlast. Flushes partial beats with an exact tkeep when a terminator item arrives.
- Sits between the output FIFO of the merger tree and the AXIS-to-memory datamover.

---
 rtl/axi_write_packer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/axi_write_packer.sv
// Packs merger-tree FIFO items into AXI4-Stream beats, frames packets with tlast and flushes partial beats on terminators.
// Optional statistics counters are built only when WRITE_PACKER_STATS_EN is defined.
module axi_write_packer #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_SORTER_BIT_WIDTH = 128,
    parameter int C_RECORD_WIDTH     = 32,
    parameter int C_BURST_BEATS      = 64
) (
    input  logic                            m_axis_aclk,
    input  logic                            m_axis_aresetn,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast,
    input  logic                            read_fifo_out,
    input  logic [C_SORTER_BIT_WIDTH-1:0]   out_fifo_item,
    output logic                            fifo_out_i_deq,
    output logic [31:0]                     stat_beats,
    output logic [31:0]                     stat_packets,
    output logic [31:0]                     stat_stall
);

    localparam int RATIO  = C_AXIS_TDATA_WIDTH / C_SORTER_BIT_WIDTH;
    localparam int KEEP_W = C_AXIS_TDATA_WIDTH / 8;
    localparam int ITEM_B = C_SORTER_BIT_WIDTH / 8;
    localparam int PCNT_W = $clog2(RATIO + 1);
    localparam int BCNT_W = $clog2(C_BURST_BEATS + 1);

    localparam logic [0:0] S_PACK  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    localparam logic [PCNT_W-1:0] LAST_SLOT = PCNT_W'(RATIO - 1);
    localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(C_BURST_BEATS - 1);
    localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);

    logic [0:0]                    r_state;
    logic [PCNT_W-1:0]             r_pack_cnt;
    logic [BCNT_W-1:0]             r_beat_cnt;
    logic [C_SORTER_BIT_WIDTH-1:0] r_slot [RATIO];
    logic                          r_tvalid;
    logic [C_AXIS_TDATA_WIDTH-1:0] r_tdata;
    logic [KEEP_W-1:0]             r_tkeep;
    logic                          r_tlast;

    logic                          w_is_term;
    logic                          w_full;
    logic                          w_completes;
    logic                          w_can_load;
    logic                          w_pop;
    logic                          w_term_load;
    logic                          w_load;
    logic [C_AXIS_TDATA_WIDTH-1:0] w_beat;
    logic [KEEP_W-1:0]             w_keep;

    assign w_is_term   = (out_fifo_item[C_RECORD_WIDTH-1:0] == '0);
    assign w_full      = ~w_is_term & (r_pack_cnt == LAST_SLOT);
    assign w_completes = w_is_term | w_full;
    assign w_can_load  = ~r_tvalid | m_axis_tready;
    assign w_pop       = read_fifo_out & (r_state == S_PACK) & (~w_completes | w_can_load);
    // A terminator with nothing open in the packet is swallowed without producing a beat.
    assign w_term_load = w_pop & w_is_term & ((r_pack_cnt != '0) | (r_beat_cnt != '0));
    assign w_load      = (w_pop & w_full) | w_term_load;

    assign fifo_out_i_deq = w_pop;

    always_comb begin
        w_beat = '0;
        w_keep = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (PCNT_W'(k) < r_pack_cnt) begin
                w_beat[k*C_SORTER_BIT_WIDTH +: C_SORTER_BIT_WIDTH] = r_slot[k];
                w_keep[k*ITEM_B +: ITEM_B] = '1;
            end else if ((PCNT_W'(k) == r_pack_cnt) && w_full) begin
                w_beat[k*C_SORTER_BIT_WIDTH +: C_SORTER_BIT_WIDTH] = out_fifo_item;
                w_keep[k*ITEM_B +: ITEM_B] = '1;
            end
        end
    end

    always_ff @(posedge m_axis_aclk) begin
        for (int k = 0; k < RATIO; k++) begin
            if (w_pop && !w_completes && (r_pack_cnt == PCNT_W'(k))) begin
                r_slot[k] <= out_fifo_item;
            end
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            r_state    <= S_PACK;
            r_pack_cnt <= '0;
            r_beat_cnt <= '0;
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
            r_tkeep    <= '0;
            r_tlast    <= 1'b0;
        end else begin
            if (w_pop) begin
                r_pack_cnt <= w_completes ? '0 : r_pack_cnt + PCNT_ONE;
                if (w_full) begin
                    r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + BCNT_ONE;
                end else if (w_is_term) begin
                    r_beat_cnt <= '0;
                end
            end
            // A load in the same cycle as an accept keeps tvalid high with the new beat.
            if (w_load) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_beat;
                r_tkeep  <= w_keep;
                r_tlast  <= w_is_term | (r_beat_cnt == LAST_BEAT);
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
            if (w_term_load) begin
                r_state <= S_DRAIN;
            end else if ((r_state == S_DRAIN) && r_tvalid && m_axis_tready) begin
                r_state <= S_PACK;
            end
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tlast  = r_tlast;

`ifdef WRITE_PACKER_STATS_EN
    logic [31:0] r_stat_beats;
    logic [31:0] r_stat_packets;
    logic [31:0] r_stat_stall;

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            r_stat_beats   <= '0;
            r_stat_packets <= '0;
            r_stat_stall   <= '0;
        end else begin
            if (r_tvalid && m_axis_tready) begin
                r_stat_beats <= r_stat_beats + 32'd1;
                if (r_tlast) begin
                    r_stat_packets <= r_stat_packets + 32'd1;
                end
            end
            if (r_tvalid && !m_axis_tready) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_beats   = r_stat_beats;
    assign stat_packets = r_stat_packets;
    assign stat_stall   = r_stat_stall;
`else
    assign stat_beats   = 32'd0;
    assign stat_packets = 32'd0;
    assign stat_stall   = 32'd0;
`endif

endmodule
